// File: rtl/ysyx_24080014_core_seq.sv
// ysyx_24080014_core_seq: multi-cycle fetch/exec/mem/writeback sequencer owning the PC
module ysyx_24080014_core_seq #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  input  logic            ifu_rsp_valid,
  output logic            ifu_rsp_ready,
  input  logic [31:0]     ifu_rsp_inst,
  input  logic            ifu_rsp_err,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_rsp_valid,
  input  logic            lsu_rsp_err,
  input  logic            is_mem,
  input  logic            is_store,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            reg_we,
  output logic            commit,
  output logic            trap,
  output logic [3:0]      trap_cause
);
  typedef enum logic [2:0] {S_FREQ, S_FWAIT, S_EXEC, S_MREQ, S_MWAIT, S_WB, S_TRAP} state_e;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [3:0] cause_q, cause_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic to_hit;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  // a response or ready in the final allowed cycle takes priority over the timeout
  assign to_hit = (TIMEOUT != 0) && (cnt_inc == TO_MAX);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    cause_d = cause_q;
    case (state_q)
      S_FREQ: begin
        if (ifu_req_ready) state_d = S_FWAIT;
        else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 4'd15;
        end
      end
      S_FWAIT: begin
        if (ifu_rsp_valid) begin
          state_d = ifu_rsp_err ? S_TRAP : S_EXEC;
          cause_d = ifu_rsp_err ? 4'd1 : cause_q;
          inst_d = ifu_rsp_err ? inst_q : ifu_rsp_inst;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 4'd15;
        end
      end
      S_EXEC: state_d = is_mem ? S_MREQ : S_WB;
      S_MREQ: begin
        if (lsu_req_ready) state_d = S_MWAIT;
        else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 4'd15;
        end
      end
      S_MWAIT: begin
        if (lsu_rsp_valid) begin
          state_d = lsu_rsp_err ? S_TRAP : S_WB;
          cause_d = lsu_rsp_err ? (is_store ? 4'd7 : 4'd5) : cause_q;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = 4'd15;
        end
      end
      S_WB: begin
        pc_d = next_pc;
        state_d = S_FREQ;
      end
      S_TRAP: begin
        pc_d = trap_vec;
        state_d = S_FREQ;
      end
      default: state_d = S_FREQ;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_inc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FREQ;
      pc_q <= RESET_PC;
      inst_q <= 32'h0000_0013;
      cause_q <= 4'd0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
    end
  end
  // every handshake and pulse is masked while reset is held
  assign ifu_req_valid = !rst && state_q == S_FREQ;
  assign ifu_rsp_ready = !rst && state_q == S_FWAIT;
  assign lsu_req_valid = !rst && state_q == S_MREQ;
  assign commit = !rst && state_q == S_WB;
  assign reg_we = !rst && state_q == S_WB && !is_store;
  assign trap = !rst && state_q == S_TRAP;
  assign trap_cause = cause_q;
  assign pc = pc_q;
  assign inst = inst_q;
endmodule

// File: tb/tb_ysyx_24080014_core_seq.sv
// tb_ysyx_24080014_core_seq: directed checks of the sequencer handshakes, traps and timeout
module tb_ysyx_24080014_core_seq;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0050_0113;
  logic clk = 1'b0;
  logic rst, ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, is_mem, is_store;
  logic reg_we, commit, trap;
  logic [31:0] ifu_rsp_inst, next_pc, trap_vec, pc, inst;
  logic [3:0] trap_cause;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign next_pc = pc + 32'd4;
  ysyx_24080014_core_seq #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .is_mem(is_mem), .is_store(is_store), .next_pc(next_pc), .trap_vec(trap_vec),
    .pc(pc), .inst(inst), .reg_we(reg_we), .commit(commit), .trap(trap), .trap_cause(trap_cause)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0; ifu_rsp_inst = ADDI;
    lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0; is_mem = 0; is_store = 0;
    trap_vec = 32'h8000_1000;
    tick();
    tick();
    chk("rst_req_valid", ifu_req_valid, 0);
    chk("rst_commit", commit, 0);
    chk("rst_trap", trap, 0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_cause", trap_cause, 0);
    rst = 0; ifu_req_ready = 1; ifu_rsp_valid = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t1_pc", pc, 32'h8000_0000 + 32'(4 * k));
      chk("t1_req_valid", ifu_req_valid, 1);
      tick();
      chk("t1_rsp_ready", ifu_rsp_ready, 1);
      tick();
      chk("t1_inst", inst, ADDI);
      chk("t1_no_commit", commit, 0);
      tick();
      chk("t1_commit", commit, 1);
      chk("t1_reg_we", reg_we, 1);
      tick();
    end
    is_mem = 1; is_store = 0;
    chk("t2_pc", pc, 32'h8000_000C);
    tick();
    tick();
    chk("t2_exec_no_lsu", lsu_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_lsu_valid_held", lsu_req_valid, 1);
      if (i == 3) lsu_req_ready = 1;
    end
    tick();
    lsu_req_ready = 0;
    chk("t2_lsu_valid_drop", lsu_req_valid, 0);
    chk("t2_wait_no_commit", commit, 0);
    tick();
    lsu_rsp_valid = 1;
    tick();
    lsu_rsp_valid = 0;
    chk("t2_commit", commit, 1);
    chk("t2_reg_we", reg_we, 1);
    chk("t2_no_trap", trap, 0);
    tick();
    chk("t2_next_pc", pc, 32'h8000_0010);
    is_store = 1; lsu_req_ready = 1; lsu_rsp_valid = 1;
    tick();
    tick();
    tick();
    chk("t3_lsu_valid", lsu_req_valid, 1);
    tick();
    chk("t3_wait_no_commit", commit, 0);
    tick();
    chk("t3_commit", commit, 1);
    chk("t3_no_reg_we", reg_we, 0);
    tick();
    chk("t3_next_pc", pc, 32'h8000_0014);
    is_mem = 0; is_store = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
    ifu_rsp_err = 1;
    tick();
    tick();
    chk("t4_trap", trap, 1);
    chk("t4_cause", trap_cause, 4'd1);
    chk("t4_no_commit", commit, 0);
    chk("t4_no_reg_we", reg_we, 0);
    ifu_rsp_err = 0; ifu_rsp_valid = 0;
    tick();
    chk("t4_vec_pc", pc, 32'h8000_1000);
    chk("t4_req_valid", ifu_req_valid, 1);
    chk("t4_trap_off", trap, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_wait_ready", ifu_rsp_ready, 1);
      chk("t5_wait_no_trap", trap, 0);
    end
    tick();
    chk("t5_timeout_trap", trap, 1);
    chk("t5_timeout_cause", trap_cause, 4'd15);
    tick();
    chk("t5_timeout_pc", pc, 32'h8000_1000);
    ifu_rsp_inst = ADDI2;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) ifu_rsp_valid = 1;
    end
    tick();
    chk("t5_race_no_trap", trap, 0);
    chk("t5_race_inst", inst, ADDI2);
    tick();
    chk("t5_race_commit", commit, 1);
    tick();
    chk("t5_race_pc", pc, 32'h8000_1004);
    is_mem = 1;
    tick();
    tick();
    tick();
    chk("t6_lsu_valid", lsu_req_valid, 1);
    rst = 1;
    #1;
    chk("t6_rst_lsu_valid", lsu_req_valid, 0);
    chk("t6_rst_commit", commit, 0);
    chk("t6_rst_trap", trap, 0);
    tick();
    rst = 0; is_mem = 0;
    #1;
    chk("t6_pc", pc, 32'h8000_0000);
    chk("t6_req_valid", ifu_req_valid, 1);
    chk("t6_lsu_idle", lsu_req_valid, 0);
    chk("t6_inst", inst, 32'h0000_0013);
    chk("t6_no_trap", trap, 0);
    is_mem = 1; lsu_req_ready = 1; lsu_rsp_valid = 1; lsu_rsp_err = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("t7_trap", trap, 1);
    chk("t7_cause", trap_cause, 4'd5);
    chk("t7_no_reg_we", reg_we, 0);
    chk("t7_no_commit", commit, 0);
    tick();
    chk("t7_vec_pc", pc, 32'h8000_1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
